mem_wb_skid: RTL and testbench
==============================

# mem_wb_skid

Parametrised MEM/WB pipeline stage with a valid/ready handshake, a one-entry skid buffer, and a synchronous flush. It carries the write-back control bits, two data words and the destination register address from the MEM stage to the WB stage. Unlike a plain clocked latch, it can apply backpressure without a combinational ready path and can squash in-flight instructions. Any write-back control bits it presents while holding no valid instruction are forced to zero, so the register file never sees a spurious write.

## Interface
- WB_W, 2, width of the write-back control field
- DATA_W, 32, width of data1/data2
- ADDR_W, 5, width of the destination register address
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous squash of all held entries and of the current input
- valid_i  in  1  upstream presents an instruction
- ready_o  out  1  stage can accept this cycle; registered, no combinational path from ready_i
- WB_i  in  WB_W  write-back control
- data1_i, data2_i  in  DATA_W  payload words
- RDaddr_i  in  ADDR_W  destination register
- valid_o  out  1  WB stage holds a valid instruction
- ready_i  in  1  downstream accepts
- WB_o  out  WB_W  main-entry control, forced to 0 when valid_o=0
- data1_o, data2_o  out  DATA_W  main-entry payload
- RDaddr_o  out  ADDR_W  main-entry destination
- occ_o  out  2  entries held: 0, 1 or 2

## Operation
- Storage: a main entry drives the outputs; a skid entry holds one overflow instruction. Each entry holds {WB, data1, data2, RDaddr}.
- Handshake events:
  - in_fire = valid_i & ready_o
  - out_fire = valid_o & ready_i
- State machine:
  - EMPTY: occ 0, valid_o=0, ready_o=1
  - BUSY: occ 1, valid_o=1, ready_o=1
  - FULL: occ 2, valid_o=1, ready_o=0
- Transitions, evaluated only when flush_i=0:
  - EMPTY: in_fire -> main<=input, go to BUSY; otherwise stay in EMPTY.
  - BUSY: in_fire & out_fire -> main<=input, stay in BUSY.
  - BUSY: in_fire & !out_fire -> skid<=input, go to FULL.
  - BUSY: !in_fire & out_fire -> go to EMPTY.
  - BUSY: neither event -> hold.
  - FULL: out_fire -> main<=skid, go to BUSY. No input can be accepted in FULL because ready_o=0.
  - FULL: !out_fire -> hold.
- Flush: flush_i=1 overrides everything.
  - Next state is EMPTY.
  - The input in that cycle is discarded even if valid_i=1.
  - Any out_fire in the flush cycle completes normally, since the outputs are already presented.
  - Payload registers may keep stale values, but WB_o reads 0 because valid_o=0.
- Output rules:
  - ready_o is registered and equals (next_state != FULL).
  - occ_o is registered and equals the state encoding.
- Ordering: strict FIFO. The skid entry always holds the younger instruction.
- No arithmetic is performed. Widths pass through unchanged.

## Timing
- Reset values: state EMPTY, valid_o=0, ready_o=1, occ_o=0, WB_o=0, data1_o=0, data2_o=0, RDaddr_o=0, skid entry all 0.
- Reset asserted mid-operation clears both entries immediately, without waiting for a clock edge.
- Latency: an instruction accepted at edge N appears on the outputs with valid_o=1 after edge N, i.e. 1 cycle.
- Throughput: 1 instruction per cycle while ready_i=1.
- Backpressure: one ready_i=0 cycle in BUSY while an input arrives fills the skid entry. ready_o drops after that edge.
- Recovery: ready_o returns to 1 after the first edge at which out_fire occurs in FULL.
- Outputs change only on clk_i edges or on reset. valid_o, WB_o and ready_o are glitch-free registered or registered-AND signals.
- valid_o and the payload outputs stay stable while valid_o=1 and ready_i=0.

## Test plan
- Reset then stream: assert rst_i, release it, then drive 4 consecutive instructions with ready_i=1, for example WB=2'b11, data1=0x10+k, RDaddr=k. Required: each appears 1 cycle later, in order; ready_o stays 1; occ_o stays 1.
- Backpressure fill: in BUSY holding A, drive B with ready_i=0. Required: occ_o=2 and ready_o=0 next cycle; A stays on the outputs. Raise ready_i: A drains, then B appears, then occ_o goes 1 -> 0.
- Full hold: in FULL, keep valid_i=1 with C for 3 cycles and ready_i=0. Required: C is not accepted, the outputs stay at A, and C is accepted only after ready_o returns to 1.
- Flush in FULL: flush_i=1 while holding A and B with valid_i=1 carrying D. Required next cycle: valid_o=0, WB_o=0, occ_o=0, ready_o=1, and D is never output.
- Async reset mid-stream: pulse rst_i between clock edges while in FULL. Required: valid_o=0, occ_o=0, ready_o=1 and all outputs 0 immediately, with no clock edge.
- Simultaneous in/out in BUSY with a changing ready_i pattern 1,0,1,1,0 over 8 instructions. Required: no loss, no duplication, FIFO order preserved, and WB_o=0 in every cycle where valid_o=0.

Source files
------------

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a valid/ready handshake, a one-entry skid buffer
// and a synchronous flush. ready_o is registered, so no combinational path exists from ready_i.
module mem_wb_skid #(
  parameter int WB_W   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [1:0]        occ_o
);

  localparam int ENTRY_W = WB_W + 2*DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  logic                valid_q;
  logic                ready_q;
  logic [ENTRY_W-1:0]  main_q;
  logic [ENTRY_W-1:0]  skid_q;
  logic [ENTRY_W-1:0]  in_entry;
  logic                in_fire;
  logic                out_fire;

  assign in_entry = {WB_i, data1_i, data2_i, RDaddr_i};
  assign in_fire  = valid_i & ready_q;
  assign out_fire = valid_q & ready_i;

  // Flush only clears the handshake state; the payload may stay stale because
  // WB_o is masked by valid_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q  <= in_entry;
            state   <= BUSY;
            valid_q <= 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_entry;
          end else if (in_fire) begin
            skid_q  <= in_entry;
            state   <= FULL;
            ready_q <= 1'b0;
          end else if (out_fire) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q  <= skid_q;
            state   <= BUSY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign occ_o    = state;
  assign WB_o     = main_q[ENTRY_W-1 -: WB_W] & {WB_W{valid_q}};
  assign data1_o  = main_q[2*DATA_W+ADDR_W-1 -: DATA_W];
  assign data2_o  = main_q[DATA_W+ADDR_W-1 -: DATA_W];
  assign RDaddr_o = main_q[ADDR_W-1:0];

endmodule

// File: tb/tb_mem_wb_skid.sv
// Self-checking bench for mem_wb_skid: directed steps plus random traffic,
// compared every cycle against a two-deep FIFO model.
module tb_mem_wb_skid;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  WB_i = '0;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [1:0]  WB_o;
  logic [31:0] data1_o;
  logic [31:0] data2_o;
  logic [4:0]  RDaddr_o;
  logic [1:0]  occ_o;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
  } entry_t;

  entry_t model_q[$];
  logic   last_in_fire;

  mem_wb_skid #(.WB_W(2), .DATA_W(32), .ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .WB_i(WB_i), .data1_i(data1_i), .data2_i(data2_i), .RDaddr_i(RDaddr_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .WB_o(WB_o), .data1_o(data1_o), .data2_o(data2_o), .RDaddr_o(RDaddr_o),
    .occ_o(occ_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The model is a FIFO of capacity two; ready is "room left", valid is "non-empty".
  task automatic checkOutput();
    logic exp_valid;
    exp_valid = (model_q.size() != 0);
    check("valid_o", valid_o, exp_valid);
    check("ready_o", ready_o, model_q.size() < 2);
    check("occ_o", occ_o, model_q.size());
    check("WB_o", WB_o, exp_valid ? model_q[0].wb : 2'b00);
    if (exp_valid) begin
      check("data1_o", data1_o, model_q[0].d1);
      check("data2_o", data2_o, model_q[0].d2);
      check("RDaddr_o", RDaddr_o, model_q[0].rd);
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    check({tag, "_valid"}, valid_o, 1'b0);
    check({tag, "_ready"}, ready_o, 1'b1);
    check({tag, "_occ"}, occ_o, 2'd0);
    check({tag, "_wb"}, WB_o, 2'd0);
    check({tag, "_data1"}, data1_o, 32'd0);
    check({tag, "_data2"}, data2_o, 32'd0);
    check({tag, "_rdaddr"}, RDaddr_o, 5'd0);
  endtask

  // Drive one cycle of inputs, clock it, advance the model, then compare.
  task automatic applyStimulus(input logic v, input logic [1:0] wb, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [4:0] rd,
                               input logic rdy, input logic fl);
    logic   in_fire, out_fire;
    entry_t e;
    valid_i = v; WB_i = wb; data1_i = d1; data2_i = d2; RDaddr_i = rd;
    ready_i = rdy; flush_i = fl;
    in_fire  = v && (model_q.size() < 2);
    out_fire = (model_q.size() != 0) && rdy;
    e = '{wb: wb, d1: d1, d2: d2, rd: rd};
    @(posedge clk_i);
    if (fl) begin
      model_q.delete();
      last_in_fire = 1'b0;
    end else begin
      if (out_fire) void'(model_q.pop_front());
      if (in_fire) model_q.push_back(e);
      last_in_fire = in_fire;
    end
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, rdy, 1'b0);
  endtask

  initial begin
    logic [1:0] pat [5];
    int idx;
    int guard;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset then stream four instructions at full rate
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    checkZeroOutputs("reset");
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, 2'b11, 32'h10 + k, $urandom, 5'(k), 1'b1, 1'b0);
    idle(1'b1);

    // Backpressure fill: A then B with ready_i low, then C held off while FULL
    applyStimulus(1'b1, 2'b01, 32'hA1, 32'hA2, 5'd10, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 32'hB1, 32'hB2, 5'd11, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 2'b11, 32'hC1, 32'hC2, 5'd12, 1'b0, 1'b0);
    guard = 0;
    do begin
      applyStimulus(1'b1, 2'b11, 32'hC1, 32'hC2, 5'd12, 1'b1, 1'b0);
      guard++;
    end while (!last_in_fire && guard < 10);
    check("C_accepted", last_in_fire, 1'b1);
    repeat (3) idle(1'b1);

    // Flush in FULL with D on the input
    applyStimulus(1'b1, 2'b01, 32'hA1, 32'hA2, 5'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 32'hB1, 32'hB2, 5'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'hD1, 32'hD2, 5'd3, 1'b0, 1'b1);
    repeat (2) idle(1'b1);

    // Asynchronous reset between edges while FULL
    applyStimulus(1'b1, 2'b11, 32'h55, 32'h66, 5'd7, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 32'h77, 32'h88, 5'd8, 1'b0, 1'b0);
    valid_i = 1'b0; ready_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    model_q.delete();
    checkZeroOutputs("async_reset");
    #1 rst_i = 1'b0;
    idle(1'b1);

    // Simultaneous in/out with a ready_i pattern 1,0,1,1,0 over 8 instructions
    idx = 0;
    guard = 0;
    while ((idx < 8 || model_q.size() != 0) && guard < 60) begin
      if (idx < 8)
        applyStimulus(1'b1, 2'(idx), 32'h100 + idx, 32'h200 + idx, 5'(idx + 16),
                      pat[guard % 5][0], 1'b0);
      else
        idle(pat[guard % 5][0]);
      if (last_in_fire) idx++;
      guard++;
    end
    check("pattern_done", (idx == 8) && (model_q.size() == 0), 1'b1);

    // Random traffic with occasional flushes
    for (int k = 0; k < 300; k++)
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom), $urandom, $urandom,
                    5'($urandom), 1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 19) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
